lifo_stack: RTL
===============

// Module: lifo_stack
// PURPOSE
//  Parametrised LIFO stack for CPU call/return and general push/pop on the bus.
//  Generalises data width and depth. Adds a registered top-of-stack output,
//  same-cycle EMPTY/FULL/COUNT, and simultaneous push+pop (replace top).
//  Adds sticky overflow/underflow error flags and an almost-full threshold.
//  Sits beside the PC/ALU datapath; the controller drives PUSH/POP one cycle at a time.
// PARAMETERS
//  DATA_W   8    width of each stack entry
//  ADDR_W   8    log2 of depth; DEPTH = 2**ADDR_W entries
//  AF_LEVEL 240  ALMOST_FULL asserts when COUNT >= AF_LEVEL (must be <= DEPTH)
// PORTS
//  CLK          in   1         clock, all state updates on rising edge
//  RESET        in   1         synchronous, active-high
//  PUSH         in   1         push DATA_IN this cycle
//  POP          in   1         pop top entry this cycle
//  DATA_IN      in   DATA_W    value to push / replace
//  CLR_ERR      in   1         clears OVERFLOW/UNDERFLOW (sync)
//  TOP          out  DATA_W    registered copy of current top entry; 0 when empty
//  COUNT        out  ADDR_W+1  number of stored entries, 0..DEPTH
//  EMPTY        out  1         COUNT == 0 (combinational from COUNT)
//  FULL         out  1         COUNT == DEPTH (combinational from COUNT)
//  ALMOST_FULL  out  1         COUNT >= AF_LEVEL
//  OVERFLOW     out  1         sticky: push attempted while FULL
//  UNDERFLOW    out  1         sticky: pop attempted while EMPTY
// BEHAVIOUR
//  Reset: COUNT=0, TOP=0, OVERFLOW=0, UNDERFLOW=0; EMPTY=1, FULL=0, ALMOST_FULL=0.
//  Reset wins over every other input. Memory contents are not cleared.
//  Storage: mem[0..COUNT-1]; mem[COUNT-1] is the top. TOP always equals mem[COUNT-1] when COUNT>0.
//  Operations, decoded from {PUSH,POP} and the pre-edge COUNT; all 1-cycle latency:
//   PUSH only, !FULL: mem[COUNT]<=DATA_IN, TOP<=DATA_IN, COUNT+1.
//   PUSH only, FULL: no state change except OVERFLOW<=1.
//   POP only, COUNT>=2: TOP<=mem[COUNT-2], COUNT-1.
//   POP only, COUNT==1: TOP<=0, COUNT<=0.
//   POP only, EMPTY: no state change except UNDERFLOW<=1.
//   PUSH+POP, !EMPTY: replace top. mem[COUNT-1]<=DATA_IN, TOP<=DATA_IN, COUNT unchanged.
//     This holds even when FULL; no error flag is set.
//   PUSH+POP, EMPTY: treated as PUSH only. No UNDERFLOW.
//   Neither: hold.
//  Error flags: set as above and held until CLR_ERR or RESET.
//   If CLR_ERR coincides with a new error, the set wins.
//  COUNT arithmetic is ADDR_W+1 bits; it never wraps (saturating by the rules above).
//  Memory index uses the low ADDR_W bits only.
//  Memory read is asynchronous (distributed RAM), used only for the mem[COUNT-2] refill on pop.
// STRUCTURE
//  Package lifo_stack_pkg holds the op-code localparams:
//   OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_ERR_OVF, OP_ERR_UNF.
//   It also holds the function decode_op(push, pop, empty, full).
//  Sub-module lifo_stack_ram: DEPTH x DATA_W, one sync write port, one async read port.
//  Top level: op decode, COUNT register, TOP register, flag logic.
// TESTING
//  1 Reset, push 0x11,0x22,0x33 -> TOP=0x33, COUNT=3; three pops -> TOP 0x22,0x11,0, EMPTY=1.
//  2 Fill DEPTH entries (value=index): FULL=1 at COUNT=256, ALMOST_FULL from COUNT=240.
//    Push 0xAA while FULL -> OVERFLOW=1, TOP=0xFF, COUNT=256.
//  3 Pop on empty -> UNDERFLOW=1, COUNT=0, TOP=0. CLR_ERR -> UNDERFLOW=0.
//    Pop on empty with CLR_ERR same cycle -> UNDERFLOW=1.
//  4 Push 0x05, then PUSH+POP with 0x77 -> TOP=0x77, COUNT=1.
//    Same when FULL -> no OVERFLOW.
//    PUSH+POP while EMPTY -> COUNT=1, TOP=DATA_IN.
//  5 Assert RESET during a push burst at COUNT=4 -> next cycle COUNT=0, TOP=0, EMPTY=1, flags 0.
//  6 Random push/pop/replace vs. queue reference model for 10k cycles, DATA_W=16, ADDR_W=4.
//    TOP, COUNT and all flags match every cycle.

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: operation codes and the
// decoder that turns the PUSH/POP request plus occupancy into one action.
package lifo_stack_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_NONE    = 3'd0;  // hold
   localparam op_t OP_PUSH    = 3'd1;  // write above the current top
   localparam op_t OP_POP     = 3'd2;  // drop the top, refill TOP from below
   localparam op_t OP_REPL    = 3'd3;  // overwrite the top in place
   localparam op_t OP_ERR_OVF = 3'd4;  // push refused, stack full
   localparam op_t OP_ERR_UNF = 3'd5;  // pop refused, stack empty

   // PUSH+POP on an empty stack has nothing to replace, so it degrades to
   // a plain push and raises no underflow. PUSH+POP on a full stack is a
   // replace and never overflows.
   function automatic op_t decode_op(input logic push,
                                     input logic pop,
                                     input logic empty,
                                     input logic full);
      op_t op;
      case ({push, pop})
         2'b10:   op = full  ? OP_ERR_OVF : OP_PUSH;
         2'b01:   op = empty ? OP_ERR_UNF : OP_POP;
         2'b11:   op = empty ? OP_PUSH    : OP_REPL;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between the controller (master) and the stack (slave).
// Signal names keep the legacy upper-case port names of the stack.
interface lifo_stack_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) ();

   logic              PUSH;
   logic              POP;
   logic [DATA_W-1:0] DATA_IN;
   logic              CLR_ERR;
   logic [DATA_W-1:0] TOP;
   logic [ADDR_W:0]   COUNT;
   logic              EMPTY;
   logic              FULL;
   logic              ALMOST_FULL;
   logic              OVERFLOW;
   logic              UNDERFLOW;

   modport master (
      output PUSH, POP, DATA_IN, CLR_ERR,
      input  TOP, COUNT, EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  PUSH, POP, DATA_IN, CLR_ERR,
      output TOP, COUNT, EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW
   );

endinterface

// File: rtl/lifo_stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port (maps onto distributed RAM). Contents are never
// reset; the occupancy count alone defines which entries are meaningful.
module lifo_stack_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];

   // Write port: one entry per clock when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with a registered top-of-stack copy, same-cycle
// occupancy status, push+pop replace, and sticky overflow/underflow flags.
module lifo_stack #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int AF_LEVEL = 240
) (
   input  logic        CLK,
   input  logic        RESET,
   lifo_stack_if.slave bus
);

   import lifo_stack_pkg::*;

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1'b1);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(2'd1);
   localparam logic [ADDR_W-1:0] IDX_TWO = ADDR_W'(2'd2);

   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] top_q,   top_d;
   logic              ovf_q,   ovf_d;
   logic              unf_q,   unf_d;

   logic              empty_s;
   logic              full_s;
   op_t               op_s;
   logic [ADDR_W-1:0] idx_free_s;   // first unused slot (count, low bits)
   logic [ADDR_W-1:0] idx_top_s;    // current top slot (count-1)
   logic [ADDR_W-1:0] idx_below_s;  // entry under the top (count-2)
   logic              we_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [DATA_W-1:0] rdata_s;

   assign empty_s = (count_q == CNT_ZERO);
   assign full_s  = (count_q == CNT_FULL);
   assign op_s    = decode_op(bus.PUSH, bus.POP, empty_s, full_s);

   // At COUNT == DEPTH the low bits wrap to zero, so count-1 / count-2 in
   // ADDR_W bits still land on the last two slots.
   assign idx_free_s  = count_q[ADDR_W-1:0];
   assign idx_top_s   = count_q[ADDR_W-1:0] - IDX_ONE;
   assign idx_below_s = count_q[ADDR_W-1:0] - IDX_TWO;

   lifo_stack_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (CLK),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (bus.DATA_IN),
      .raddr (idx_below_s),
      .rdata (rdata_s)
   );

   // Next-state decode: count, top copy, memory write and sticky flags.
   always_comb begin
      count_d = count_q;
      top_d   = top_q;
      we_s    = 1'b0;
      waddr_s = idx_free_s;
      // A clear request drops the flags unless a new error sets them again
      // in the same cycle; the set below overrides this.
      ovf_d   = ovf_q & ~bus.CLR_ERR;
      unf_d   = unf_q & ~bus.CLR_ERR;

      case (op_s)
         OP_PUSH: begin
            we_s    = 1'b1;
            waddr_s = idx_free_s;
            top_d   = bus.DATA_IN;
            count_d = count_q + CNT_ONE;
         end
         OP_POP: begin
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               top_d = {DATA_W{1'b0}};
            end else begin
               top_d = rdata_s;
            end
         end
         OP_REPL: begin
            we_s    = 1'b1;
            waddr_s = idx_top_s;
            top_d   = bus.DATA_IN;
         end
         OP_ERR_OVF: begin
            ovf_d = 1'b1;
         end
         OP_ERR_UNF: begin
            unf_d = 1'b1;
         end
         default: begin
            count_d = count_q;
         end
      endcase

      // Reset wins: no write lands in memory during a reset cycle.
      if (RESET) begin
         we_s = 1'b0;
      end else begin
         we_s = we_s;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q <= CNT_ZERO;
         top_q   <= {DATA_W{1'b0}};
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         top_q   <= top_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.TOP         = top_q;
   assign bus.COUNT       = count_q;
   assign bus.EMPTY       = empty_s;
   assign bus.FULL        = full_s;
   assign bus.ALMOST_FULL = (count_q >= CNT_AF);
   assign bus.OVERFLOW    = ovf_q;
   assign bus.UNDERFLOW   = unf_q;

endmodule
